// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte streams; a grant covers one message (req_last) or MAX_BURST bytes.
// Optional UART_ARB_TAG_EN: each grant is prefixed with an ASCII tag byte "0"+grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;
  logic [DATA_W-1:0] sel_data;

  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign sel_data = req_data[int'(grant_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(8'h30) + DATA_W'(grant_q);
        if (tx_ready) state_d = STREAM;
      end
`endif
      STREAM: begin
        tx_data            = sel_data;
        tx_valid           = req_valid[grant_q];
        req_ready[grant_q] = tx_ready;
        if (req_valid[grant_q] && tx_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (req_last[grant_q] || cnt_q == CNT_LAST) begin
            busy_d  = 1'b0;
            ptr_d   = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (default build): directed scenarios plus randomized traffic
// checked against a message-level round-robin model of the byte stream.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [DW-1:0]     tx_data;
  logic              tx_valid, tx_ready;
  logic [1:0]        grant_id;
  logic              busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  // Per-requester byte queues: bit 8 is the last flag.
  logic [8:0]  mem [NR][128];
  int          head [NR];
  int          tail [NR];
  logic [NR-1:0] en;
  logic [NR-1:0] acc;
  logic        rdy_rand, rdy_val;
  int          cyc;
  logic [9:0]  obs_q [$];
  int          obs_cyc [$];
  logic [9:0]  exp_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && head[i] < tail[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = mem[i][head[i]][7:0];
        req_last[i]           = mem[i][head[i]][8];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  endtask

  task automatic sample();
    acc = req_valid & req_ready;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (tx_valid && tx_ready) begin
      obs_q.push_back({grant_id, tx_data});
      obs_cyc.push_back(cyc);
      chk("hs_pair", acc[grant_id], 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
    acc = '0;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '1;
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic push_msg(input int r, input string s, input bit last_at_end);
    for (int k = 0; k < s.len(); k++) begin
      mem[r][tail[r]] = {last_at_end && (k == s.len() - 1), s[k]};
      tail[r]++;
    end
  endtask

  // Message-level round robin over what is queued now; all requesters assumed visible.
  task automatic build_exp();
    int  h [NR];
    int  ptr, g, n, c;
    bit  rel, stuck;
    exp_q.delete();
    for (int i = 0; i < NR; i++) h[i] = head[i];
    ptr = NR - 1;
    stuck = 1'b0;
    while (!stuck) begin
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (ptr + k) % NR;
        if (g < 0 && h[c] < tail[c]) g = c;
      end
      if (g < 0) break;
      n = 0;
      rel = 1'b0;
      while (!rel && !stuck) begin
        exp_q.push_back({2'(g), mem[g][h[g]][7:0]});
        n++;
        rel = mem[g][h[g]][8] || (n == MB);
        h[g]++;
        if (!rel && h[g] >= tail[g]) stuck = 1'b1;
      end
      ptr = g;
    end
  endtask

  task automatic run_drain(input string tag, input int bound);
    int n = 0;
    while (n < bound && !all_empty()) begin tick(); n++; end
    repeat (3) tick();
    chk({tag, "_drain_done"}, all_empty(), 1);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    rst = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    acc = '0; cyc = 0; en = '1; rdy_rand = 1'b0; rdy_val = 1'b1;

    // Reset values and the "hi" message with its 1-cycle arbitration latency
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    push_msg(0, "hi", 1'b1);
    tick();
    chk("t1_arb_cycle_vld", tx_valid, 0);
    tick();
    chk("t1_first_vld", tx_valid, 1);
    chk("t1_first_dat", tx_data, 8'h68);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_second_dat", tx_data, 8'h69);
    tick();
    chk("t1_busy_drop", busy, 0);
    chk("t1_idle_vld", tx_valid, 0);

    // Two simultaneous 3-byte messages, one idle cycle between them
    do_reset();
    push_msg(1, "abc", 1'b1);
    push_msg(2, "xyz", 1'b1);
    build_exp();
    run_drain("t2", 200);
    if (obs_cyc.size() >= 4) chk("t2_gap", obs_cyc[3] - obs_cyc[2], 2);
    else chk("t2_gap_count", obs_cyc.size(), 6);

    // 20-byte stream without last: forced rotation at MAX_BURST
    do_reset();
    for (int k = 0; k < 20; k++) begin
      mem[0][tail[0]] = {1'b0, 8'(8'h40 + k)};
      tail[0]++;
    end
    push_msg(3, "XYZ", 1'b1);
    build_exp();
    run_drain("t3", 300);
    chk("t3_hold_busy", busy, 1);
    chk("t3_hold_grant", grant_id, 0);

    // Transmitter stalls mid-message
    do_reset();
    push_msg(1, "ABCDEF", 1'b1);
    build_exp();
    repeat (3) tick();
    rdy_val = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_stall_dat", tx_data, 8'h43);
      chk("t4_stall_grant", grant_id, 1);
      chk("t4_stall_vld", tx_valid, 1);
    end
    rdy_val = 1'b1;
    run_drain("t4", 200);

    // Reset pulse during a req2 message
    do_reset();
    en = 4'b1110;
    push_msg(2, "MNOPQR", 1'b1);
    push_msg(0, "Z0", 1'b1);
    repeat (3) tick();
    rdy_val = 1'b0;
    en = '1;
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_vld", tx_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_grant", grant_id, 0);
    rst = 1'b0;
    rdy_val = 1'b1;
    obs_q.delete();
    obs_cyc.delete();
    build_exp();
    tick();
    chk("t5_regrant_id", grant_id, 0);
    chk("t5_regrant_vld", tx_valid, 1);
    run_drain("t5", 200);

    // Randomized traffic with random transmitter backpressure
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(0, 30);
        for (int k = 0; k < n; k++) begin
          mem[i][tail[i]] = {($urandom_range(0, 3) == 0) || (k == n - 1), 8'($urandom)};
          tail[i]++;
        end
      end
      rdy_rand = 1'b1;
      build_exp();
      run_drain($sformatf("rnd%0d", r), 2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
